// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the core data port and byte-lane data memory.
// Stores are queued and retired one per cycle in order; loads are forwarded
// from the youngest matching buffered store or read from memory.
module mem_write_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_busy,
    output logic        empty,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in [0:3],
    output logic        mem_write_en,
    input  logic [7:0]  mem_data_out [0:3]
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned LatW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    typedef enum logic [2:0] {StIdle, StDrain, StRdCheck, StRdMem, StRdResp} state_e;

    state_e          state_q, state_d;
    logic [29:0]     addr_q [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, scan_idx;
    logic [CntW-1:0] count_q, count_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic [31:0]     mem_addr_q, mem_wdata_q, mem_wdata, mem_rdata;
    logic            push, pop, hit;
    logic [31:0]     hit_data;
    logic            unused_lsbs;

    // Stores are compared and retired as whole words.
    assign unused_lsbs = ^{wr_addr[1:0]};

    assign wr_ready = (count_q < CntW'(DEPTH));
    assign push     = wr_req & wr_ready;
    assign pop      = (state_q == StDrain);
    assign count_d  = count_q + CntW'(push) - CntW'(pop);
    assign head_d   = pop  ? head_q + PtrW'(1) : head_q;
    assign tail_d   = push ? tail_q + PtrW'(1) : tail_q;

    assign rd_valid = (state_q == StRdResp);
    assign rd_busy  = (state_q == StRdCheck) || (state_q == StRdMem) || (state_q == StRdResp);
    assign rd_data  = rd_data_q;
    assign empty    = (count_q == '0) && (state_q != StDrain);
    assign mem_rdata = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};

    // Lane split of the outgoing store word.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mem_data_in[k] = mem_wdata[8*k +: 8];
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PtrW'(i);
            if ((CntW'(i) < count_q) && (addr_q[scan_idx] == rd_addr[31:2])) begin
                hit      = 1'b1;
                hit_data = data_q[scan_idx];
            end
        end
    end

    // Next-state and memory-port outputs; address/data hold when not driven.
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        rd_data_d    = rd_data_q;
        mem_write_en = 1'b0;
        mem_addr     = mem_addr_q;
        mem_wdata    = mem_wdata_q;
        unique case (state_q)
            StIdle, StDrain: begin
                if (state_q == StDrain) begin
                    // Gated by reset so an aborted drain never reaches memory.
                    mem_write_en = ~rst_b;
                    mem_addr     = {addr_q[head_q], 2'b00};
                    mem_wdata    = data_q[head_q];
                end
                if (rd_req) begin
                    state_d = StRdCheck;
                end else if (count_d != '0) begin
                    state_d = StDrain;
                end else begin
                    state_d = StIdle;
                end
            end
            StRdCheck: begin
                lat_d = '0;
                if (hit) begin
                    rd_data_d = hit_data;
                    state_d   = StRdResp;
                end else begin
                    state_d = StRdMem;
                end
            end
            StRdMem: begin
                mem_addr = rd_addr;
                if (lat_q == LatW'(MEM_RD_LAT - 1)) begin
                    rd_data_d = mem_rdata;
                    state_d   = StRdResp;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            StRdResp: begin
                state_d = (count_d != '0) ? StDrain : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q     <= StIdle;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            lat_q       <= '0;
            rd_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            lat_q       <= lat_d;
            rd_data_q   <= rd_data_d;
            mem_addr_q  <= mem_addr;
            mem_wdata_q <= mem_wdata;
        end
    end

    // Entry storage; validity is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= wr_addr[31:2];
            data_q[tail_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer with a byte-lane memory model that only
// returns valid read data once the address has been held for MEM_RD_LAT cycles.
module tb_mem_write_buffer;

    localparam int DEPTH = 4;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        wr_req, rd_req;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic        wr_ready, rd_valid, rd_busy, empty, mem_write_en;
    logic [31:0] rd_data, mem_addr;
    logic [7:0]  mem_data_in [0:3];
    logic [7:0]  mem_data_out [0:3];

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] rd_word, last_addr;
    int          hold, wr_cnt, wc0;
    logic        poke_en;
    logic [31:0] poke_addr, poke_data;
    int          n_assert = 0;
    int          n_fail = 0;

    mem_write_buffer #(.DEPTH(DEPTH), .MEM_RD_LAT(LAT)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .empty       (empty),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_write_en(mem_write_en),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Memory model: writes, test pokes and address-hold tracking.
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr[9:2]] <= poke_data;
        if (mem_write_en) begin
            mem[mem_addr[9:2]] <= {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};
            wr_cnt <= wr_cnt + 1;
        end
        hold      <= (mem_addr == last_addr) ? hold + 1 : 1;
        last_addr <= mem_addr;
    end

    // Read data is garbage until the address has been stable long enough.
    always_comb begin
        rd_word = ((LAT == 1) || (hold >= LAT - 1 && last_addr == mem_addr))
                  ? mem[mem_addr[9:2]] : 32'hBADBAD00;
        for (int k = 0; k < 4; k++) mem_data_out[k] = rd_word[8*k +: 8];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        cyc();
        poke_en = 1'b0;
        ref_mem[a[9:2]] = d;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!empty && n < 50) begin cyc(); n++; end
        chk(tag, empty, 1);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        while (!wr_ready && n < 40) begin cyc(); n++; end
        chk("push_ready", wr_ready, 1);
        cyc();
        wr_req = 1'b0;
        ref_mem[a[9:2]] = d;
    endtask

    task automatic load(input logic [31:0] a);
        int n = 0;
        rd_req = 1'b1; rd_addr = a;
        do begin cyc(); n++; end while (!rd_valid && n < 40);
        chk("load_valid", rd_valid, 1);
        chk("load_data", rd_data, ref_mem[a[9:2]]);
        rd_req = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        rst_b = 1'b1; wr_req = 1'b0; rd_req = 1'b0; poke_en = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0; poke_addr = '0; poke_data = '0;

        // T1: reset state, then reset while the first drain cycle is live.
        cyc(); cyc();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_write_en", mem_write_en, 0);
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_b = 1'b0;
        wr_req = 1'b1; wr_addr = 32'h80; wr_data = 32'h12345678;
        cyc();
        wr_req = 1'b0;
        chk("t1_drain_started", mem_write_en, 1);
        rst_b = 1'b1;
        #1;
        chk("t1_write_gated", mem_write_en, 0);
        cyc();
        rst_b = 1'b0;
        chk("t1_empty_after", empty, 1);
        cyc();
        chk("t1_no_write_en", mem_write_en, 0);
        chk("t1_no_writes", wr_cnt, 0);

        // T2: three back-to-back stores drain in order, one per cycle.
        wr_req = 1'b1; wr_addr = 32'h10; wr_data = 32'h11111111;
        cyc();
        chk("t2_en0", mem_write_en, 1);
        chk("t2_addr0", mem_addr, 32'h10);
        chk("t2_lane0", mem_data_in[0], 8'h11);
        wr_addr = 32'h14; wr_data = 32'h22222222;
        cyc();
        chk("t2_en1", mem_write_en, 1);
        chk("t2_addr1", mem_addr, 32'h14);
        chk("t2_lane1", mem_data_in[3], 8'h22);
        wr_addr = 32'h18; wr_data = 32'h33333333;
        cyc();
        wr_req = 1'b0;
        chk("t2_en2", mem_write_en, 1);
        chk("t2_addr2", mem_addr, 32'h18);
        chk("t2_lane2", mem_data_in[1], 8'h33);
        cyc();
        chk("t2_en_done", mem_write_en, 0);
        chk("t2_empty", empty, 1);
        chk("t2_addr_hold", mem_addr, 32'h18);
        chk("t2_count", wr_cnt, 3);
        chk("t2_mem14", mem[5], 32'h22222222);

        // T3: full buffer while a miss load sits in the memory read.
        poke(32'h100, 32'hCAFEF00D);
        wc0 = wr_cnt;
        rd_req = 1'b1; rd_addr = 32'h100;
        cyc();
        chk("t3_busy", rd_busy, 1);
        cyc();
        chk("t3_mem_addr", mem_addr, 32'h100);
        chk("t3_no_write", mem_write_en, 0);
        wr_req = 1'b1; wr_addr = 32'h200; wr_data = 32'hA0A0A0A0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            wr_addr = wr_addr + 32'd4; wr_data = wr_data + 32'd1;
        end
        chk("t3_not_yet_valid", rd_valid, 0);
        chk("t3_ready_at3", wr_ready, 1);
        cyc();
        wr_addr = 32'h210; wr_data = 32'hA0A0A0A4;
        chk("t3_full", wr_ready, 0);
        chk("t3_rd_valid", rd_valid, 1);
        chk("t3_rd_data", rd_data, 32'hCAFEF00D);
        rd_req = 1'b0;
        cyc();
        chk("t3_full_drain", wr_ready, 0);
        chk("t3_drain_en", mem_write_en, 1);
        chk("t3_drain_addr", mem_addr, 32'h200);
        cyc();
        chk("t3_ready_again", wr_ready, 1);
        chk("t3_drain_addr2", mem_addr, 32'h204);
        cyc();
        wr_req = 1'b0;
        wait_empty("t3_empty");
        chk("t3_write_count", wr_cnt - wc0, 5);
        chk("t3_mem210", mem[8'h84], 32'hA0A0A0A4);

        // T4: forward the youngest of two stores to the same word.
        poke(32'h300, 32'h30303030);
        rd_req = 1'b1; rd_addr = 32'h300;
        cyc(); cyc();
        wr_req = 1'b1; wr_addr = 32'h30; wr_data = 32'h55555555;
        cyc();
        wr_addr = 32'h20; wr_data = 32'hAABBCCDD;
        cyc();
        wr_data = 32'h11223344;
        cyc();
        wr_req = 1'b0;
        cyc();
        chk("t4_pre_valid", rd_valid, 1);
        chk("t4_pre_data", rd_data, 32'h30303030);
        rd_req = 1'b0;
        cyc();
        chk("t4_drain30", mem_addr, 32'h30);
        rd_req = 1'b1; rd_addr = 32'h22;
        cyc();
        chk("t4_check_no_write", mem_write_en, 0);
        chk("t4_check_no_valid", rd_valid, 0);
        cyc();
        chk("t4_valid", rd_valid, 1);
        chk("t4_fwd_data", rd_data, 32'h11223344);
        chk("t4_resp_no_write", mem_write_en, 0);
        rd_req = 1'b0;
        cyc();
        chk("t4_w1_addr", mem_addr, 32'h20);
        chk("t4_w1_lane0", mem_data_in[0], 8'hDD);
        chk("t4_w1_lane3", mem_data_in[3], 8'hAA);
        cyc();
        chk("t4_w2_lane0", mem_data_in[0], 8'h44);
        wait_empty("t4_empty");
        chk("t4_mem20", mem[8], 32'h11223344);

        // T5: miss bypasses a pending store to a different word.
        poke(32'h40, 32'hDEADBEEF);
        wr_req = 1'b1; wr_addr = 32'h44; wr_data = 32'h44444444;
        rd_req = 1'b1; rd_addr = 32'h40;
        cyc();
        wr_req = 1'b0;
        chk("t5_check_no_write", mem_write_en, 0);
        cyc(); cyc(); cyc(); cyc();
        chk("t5_not_yet_valid", rd_valid, 0);
        cyc();
        chk("t5_valid", rd_valid, 1);
        chk("t5_data", rd_data, 32'hDEADBEEF);
        rd_req = 1'b0;
        cyc();
        chk("t5_store_after", mem_write_en, 1);
        chk("t5_store_addr", mem_addr, 32'h44);
        wait_empty("t5_empty");

        // Store pushed on the same edge the load starts is forwarded.
        wr_req = 1'b1; wr_addr = 32'h50; wr_data = 32'h50505050;
        rd_req = 1'b1; rd_addr = 32'h50;
        cyc();
        wr_req = 1'b0;
        cyc();
        chk("t5b_valid", rd_valid, 1);
        chk("t5b_data", rd_data, 32'h50505050);
        rd_req = 1'b0;
        wait_empty("t5b_empty");

        // T6: pointer wrap with interleaved loads against a program-order image.
        wc0 = wr_cnt;
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            a = 32'h180 + 32'(4 * (i % 5));
            d = 32'h5A000000 + 32'(i * 32'h00010101);
            push(a, d);
            if (i % 3 == 2) load(32'h180 + 32'(4 * ((i - 1) % 5)) + 32'(i % 4));
        end
        wait_empty("t6_empty");
        for (int k = 0; k < 5; k++) chk("t6_image", mem[96 + k], ref_mem[96 + k]);
        chk("t6_write_count", wr_cnt - wc0, 3 * DEPTH + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
